// File: rtl/tg2_mem_perf_mon.sv
// Multi-channel TG duration/status monitor with a pipelined Avalon-MM CSR read port.
// Define TG2_PERF_WATCHDOG_EN to add per-channel watchdog LIMIT registers at the COUNT addresses.
module tg2_mem_perf_mon #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 48,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] tg_start,
  input  logic [NUM_CH-1:0] tg_pass,
  input  logic [NUM_CH-1:0] tg_fail,
  input  logic [NUM_CH-1:0] tg_timeout,
  input  logic [ADDR_W-1:0] csr_address,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [DATA_W-1:0] csr_writedata,
  output logic              csr_waitrequest,
  output logic [DATA_W-1:0] csr_readdata,
  output logic              csr_readdatavalid,
  output logic [NUM_CH-1:0] ch_done,
  output logic              all_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Status word per channel: [4] OVF, [3] WD, [2] TIMEOUT, [1] FAIL, [0] PASS
  state_e             state_q [NUM_CH];
  state_e             state_d [NUM_CH];
  logic [CNT_W-1:0]   cnt_q   [NUM_CH];
  logic [CNT_W-1:0]   cnt_d   [NUM_CH];
  logic [4:0]         sts_q   [NUM_CH];
  logic [4:0]         sts_d   [NUM_CH];
  logic [NUM_CH-1:0]  ch_done_q, ch_done_d;
  logic               all_done_q, all_done_d;
  logic               wait_q, wait_d;
  logic [NUM_CH-1:0]  clr;
  logic               rd_acc, wr_acc;
  logic [DATA_W-1:0]  rd_data_p1_q, rd_data_p1_d;
  logic               vld_p1_q, vld_p1_d;
  logic [DATA_W-1:0]  rd_data_p2_q, rd_data_p2_d;
  logic               vld_p2_q, vld_p2_d;
  logic               unused_wdata;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign unused_wdata = ^csr_writedata;
  assign rd_acc = csr_read & ~wait_q;
  assign wr_acc = csr_write & ~wait_q;
  assign wait_d = 1'b0;

  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      clr[i] = wr_acc && (csr_address == ADDR_W'(2 * i + 1)) && csr_writedata[0];
    end
  end

`ifdef TG2_PERF_WATCHDOG_EN
  logic [CNT_W-1:0] lim_q [NUM_CH];
  logic [CNT_W-1:0] lim_d [NUM_CH];

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      lim_d[i] = lim_q[i];
      if (wr_acc && (csr_address == ADDR_W'(2 * i))) begin
        lim_d[i] = csr_writedata[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) lim_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) lim_q[i] <= lim_d[i];
    end
  end
`endif

  // Channel FSMs: clear beats start, start beats completion, completion beats watchdog.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      sts_d[i]   = sts_q[i];
      if (clr[i]) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
        sts_d[i]   = '0;
      end else if (tg_start[i]) begin
        state_d[i] = ST_RUN;
        cnt_d[i]   = '0;
        sts_d[i]   = '0;
      end else if (state_q[i] == ST_RUN) begin
        cnt_d[i] = sat_inc(cnt_q[i]);
        if (cnt_q[i] == CNT_MAX) sts_d[i][4] = 1'b1;
`ifdef TG2_PERF_WATCHDOG_EN
        if ((lim_q[i] != '0) && (cnt_q[i] == lim_q[i] - CNT_W'(1))) begin
          state_d[i]  = ST_DONE;
          sts_d[i][3] = 1'b1;
        end
`endif
        if (tg_pass[i] | tg_fail[i] | tg_timeout[i]) begin
          state_d[i]    = ST_DONE;
          sts_d[i][3]   = 1'b0;
          sts_d[i][2:0] = {tg_timeout[i], tg_fail[i], tg_pass[i]};
        end
      end
      ch_done_d[i] = (state_d[i] == ST_DONE);
    end
    all_done_d = &ch_done_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
        sts_q[i]   <= '0;
      end
      ch_done_q  <= '0;
      all_done_q <= 1'b0;
      wait_q     <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        sts_q[i]   <= sts_d[i];
      end
      ch_done_q  <= ch_done_d;
      all_done_q <= all_done_d;
      wait_q     <= wait_d;
    end
  end

  // Stage p1: address decode on pre-write state, registered
  always_comb begin
    rd_data_p1_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (csr_address == ADDR_W'(2 * i))     rd_data_p1_d = DATA_W'(cnt_q[i]);
      if (csr_address == ADDR_W'(2 * i + 1)) rd_data_p1_d = DATA_W'({state_q[i], sts_q[i]});
    end
    if (csr_address == ADDR_W'(2 * NUM_CH)) rd_data_p1_d = DATA_W'({all_done_q, ch_done_q});
    vld_p1_d = rd_acc;
  end

  // Stage p2: output register, holds last data while no response is due
  always_comb begin
    rd_data_p2_d = vld_p1_q ? rd_data_p1_q : rd_data_p2_q;
    vld_p2_d     = vld_p1_q;
  end

  always_ff @(posedge clk) begin
    rd_data_p1_q <= rd_data_p1_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      rd_data_p2_q <= '0;
    end else begin
      vld_p1_q     <= vld_p1_d;
      vld_p2_q     <= vld_p2_d;
      rd_data_p2_q <= rd_data_p2_d;
    end
  end

  assign csr_waitrequest   = wait_q;
  assign csr_readdata      = rd_data_p2_q;
  assign csr_readdatavalid = vld_p2_q;
  assign ch_done           = ch_done_q;
  assign all_done          = all_done_q;

endmodule
